// File: rtl/load_store_unit_pkg.sv
// Shared opcodes, FSM state type and store-side request decode for the load/store unit.
package load_store_unit_pkg;

    localparam logic [5:0] OPCODE_LB  = 6'h20;
    localparam logic [5:0] OPCODE_LH  = 6'h21;
    localparam logic [5:0] OPCODE_LWL = 6'h22;
    localparam logic [5:0] OPCODE_LW  = 6'h23;
    localparam logic [5:0] OPCODE_LBU = 6'h24;
    localparam logic [5:0] OPCODE_LHU = 6'h25;
    localparam logic [5:0] OPCODE_LWR = 6'h26;
    localparam logic [5:0] OPCODE_SB  = 6'h28;
    localparam logic [5:0] OPCODE_SH  = 6'h29;
    localparam logic [5:0] OPCODE_SW  = 6'h2B;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} lsu_state_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [1:0]  off;
    } lsu_req_t;

    // Lane offset is forced aligned for half/word ops so a misaligned access still proceeds.
    function automatic lsu_req_t lsu_decode(input logic [5:0] op, input logic [1:0] a,
                                            input logic [31:0] rt);
        lsu_req_t r;
        r = '0;
        r.off = a;
        case (op)
            OPCODE_LB, OPCODE_LBU: begin r.rd = 1'b1; r.be = 4'b0001 << a; end
            OPCODE_SB: begin r.wr = 1'b1; r.be = 4'b0001 << a; r.wdata = {4{rt[7:0]}}; end
            OPCODE_LH, OPCODE_LHU: begin
                r.off = {a[1], 1'b0}; r.rd = 1'b1; r.be = 4'b0011 << r.off;
            end
            OPCODE_SH: begin
                r.off = {a[1], 1'b0}; r.wr = 1'b1; r.be = 4'b0011 << r.off;
                r.wdata = {2{rt[15:0]}};
            end
            OPCODE_LW:  begin r.off = 2'd0; r.rd = 1'b1; r.be = 4'b1111; end
            OPCODE_SW:  begin r.off = 2'd0; r.wr = 1'b1; r.be = 4'b1111; r.wdata = rt; end
            OPCODE_LWL: begin r.rd = 1'b1; r.be = (4'b0010 << a) - 4'd1; end
            OPCODE_LWR: begin r.rd = 1'b1; r.be = 4'b1111 << a; end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic lsu_misaligned(input logic [5:0] op, input logic [1:0] a);
        return ((op == OPCODE_LW || op == OPCODE_SW) && a != 2'd0) ||
               ((op == OPCODE_LH || op == OPCODE_LHU || op == OPCODE_SH) && a[0]);
    endfunction

endpackage

// File: rtl/load_store_unit_load_extension.sv
// Combinational load writeback formation: byte/half extraction, extension and LWL/LWR merge.
import load_store_unit_pkg::*;

module load_extension (
    input  logic [5:0]  opcode,
    input  logic [1:0]  offset,
    input  logic [31:0] readdata,
    input  logic [31:0] rt,
    output logic [31:0] result
);
    logic [31:0] shifted;
    logic [4:0]  lane_sh;
    logic [4:0]  lwl_sh;
    logic [4:0]  lwl_mask_sh;

    assign lane_sh     = {offset, 3'b000};
    assign lwl_sh      = {2'd3 - offset, 3'b000};
    assign lwl_mask_sh = {offset + 2'd1, 3'b000};
    assign shifted     = readdata >> lane_sh;

    always_comb begin
        result = 32'd0;
        case (opcode)
            OPCODE_LB:  result = {{24{shifted[7]}}, shifted[7:0]};
            OPCODE_LBU: result = {24'd0, shifted[7:0]};
            OPCODE_LH:  result = {{16{shifted[15]}}, shifted[15:0]};
            OPCODE_LHU: result = {16'd0, shifted[15:0]};
            OPCODE_LW:  result = readdata;
            // offset 3 would need a 32-bit mask shift; the word alone is the answer there
            OPCODE_LWL: result = (offset == 2'd3) ? readdata :
                                 (readdata << lwl_sh) | (rt & (32'hFFFF_FFFF >> lwl_mask_sh));
            OPCODE_LWR: result = shifted | (rt & ~(32'hFFFF_FFFF >> lane_sh));
            default:    result = 32'd0;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE/ACCESS/DONE sequencer driving a word-addressed wait-state bus.
// Optional MISALIGN_TRAP_EN turns misaligned half/word accesses into faults with no bus cycle.
import load_store_unit_pkg::*;

module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] eff_address,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_result,
    output logic        fault,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest
);
    lsu_state_t  state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rt_q, rt_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, result_q, result_d;
    logic        rd_q, rd_d, wr_q, wr_d, fault_q, fault_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] ext_result;
    logic        mis;
    lsu_req_t    req;

    assign req = lsu_decode(opcode, eff_address[1:0], rt_data);
`ifdef MISALIGN_TRAP_EN
    assign mis = lsu_misaligned(opcode, eff_address[1:0]);
`else
    assign mis = 1'b0;
`endif

    load_extension u_ext (
        .opcode   (op_q),
        .offset   (off_q),
        .readdata (mem_readdata),
        .rt       (rt_q),
        .result   (ext_result)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        off_d    = off_q;
        rt_d     = rt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        result_d = result_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        be_d     = be_q;
        fault_d  = fault_q;
        case (state_q)
            IDLE: if (start) begin
                op_d  = opcode;
                off_d = req.off;
                rt_d  = rt_data;
                if (mis || !(req.rd || req.wr)) begin
                    state_d  = DONE;
                    result_d = 32'd0;
                    fault_d  = mis;
                end else begin
                    state_d = ACCESS;
                    addr_d  = {eff_address[31:2], 2'b00};
                    rd_d    = req.rd;
                    wr_d    = req.wr;
                    be_d    = req.be;
                    wdata_d = req.wdata;
                end
            end
            ACCESS: if (!mem_waitrequest) begin
                state_d  = DONE;
                rd_d     = 1'b0;
                wr_d     = 1'b0;
                result_d = ext_result;
                fault_d  = 1'b0;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 6'd0;
            off_q    <= 2'd0;
            rt_q     <= 32'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            result_q <= 32'd0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            be_q     <= 4'd0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            off_q    <= off_d;
            rt_q     <= rt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            be_q     <= be_d;
            fault_q  <= fault_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign load_result    = result_q;
    assign fault          = fault_q;
    assign mem_address    = addr_q;
    assign mem_read       = rd_q;
    assign mem_write      = wr_q;
    assign mem_byteenable = be_q;
    assign mem_writedata  = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit; bus responder with programmable wait states.
import load_store_unit_pkg::*;

module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [31:0] eff_address = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        busy, done, fault, mem_read, mem_write;
    logic [31:0] load_result, mem_address, mem_writedata;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata = 32'd0;
    logic        mem_waitrequest = 1'b0;

    typedef struct {
        logic [31:0] res;
        logic        flt;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .eff_address(eff_address), .rt_data(rt_data), .busy(busy), .done(done),
        .load_result(load_result), .fault(fault), .mem_address(mem_address),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_waitrequest(mem_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // bus: 1 if a bus cycle is expected; wd checked only for stores
    task automatic run(input string tag, input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] rt, input logic [31:0] rdata, input int waits,
                       input bit bus, input bit is_wr, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] res, input logic flt,
                       input bit noise);
        int cyc, acc;
        bit seen;
        exp_t e;
        sb.push_back('{res: res, flt: flt});
        @(negedge clk);
        start = 1'b1; opcode = op; eff_address = addr; rt_data = rt;
        mem_readdata = rdata; mem_waitrequest = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0; acc = 0; seen = 1'b0;
        while (!seen && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
            else if (mem_read || mem_write) begin
                acc++;
                chk({tag, " addr"}, mem_address, {addr[31:2], 2'b00});
                chk({tag, " be"}, {28'd0, mem_byteenable}, {28'd0, be});
                chk({tag, " rdwr"}, {30'd0, mem_read, mem_write}, {30'd0, !is_wr, is_wr});
                if (is_wr) chk({tag, " wdata"}, mem_writedata, wd);
                mem_waitrequest = (acc <= waits);
                if (noise) begin
                    start = 1'b1; opcode = OPCODE_SW; eff_address = 32'hFFFF_FFF0;
                end
            end
        end
        start = 1'b0;
        mem_waitrequest = 1'b0;
        chk({tag, " done_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, " latency"}, cyc, bus ? waits + 2 : 1);
        chk({tag, " bus_cycles"}, acc, bus ? waits + 1 : 0);
        chk({tag, " bus_idle_at_done"}, {30'd0, mem_read, mem_write}, 32'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " result"}, load_result, e.res);
            chk({tag, " fault"}, {31'd0, fault}, {31'd0, e.flt});
        end
        @(negedge clk);
        chk({tag, " hold"}, load_result, res);
        chk({tag, " idle_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        #12;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst fault", {31'd0, fault}, 32'd0);
        chk("rst rdwr", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst result", load_result, 32'd0);
        chk("rst addr", mem_address, 32'd0);
        chk("rst wdata", mem_writedata, 32'd0);
        chk("rst be", {28'd0, mem_byteenable}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run("lb", OPCODE_LB, 32'h1003, 32'h0, 32'h80FF1234, 0, 1, 0, 4'b1000, 32'h0,
            32'hFFFFFF80, 1'b0, 0);
        run("lhu", OPCODE_LHU, 32'h1002, 32'h0, 32'h8001ABCD, 3, 1, 0, 4'b1100, 32'h0,
            32'h00008001, 1'b0, 1);
        run("sb", OPCODE_SB, 32'h2001, 32'h000000A5, 32'h0, 0, 1, 1, 4'b0010, 32'hA5A5A5A5,
            32'h0, 1'b0, 0);
        run("lwl", OPCODE_LWL, 32'h4001, 32'hAABBCCDD, 32'h44332211, 0, 1, 0, 4'b0011, 32'h0,
            32'h2211CCDD, 1'b0, 0);
        run("lwr", OPCODE_LWR, 32'h4001, 32'hAABBCCDD, 32'h44332211, 1, 1, 0, 4'b1110, 32'h0,
            32'hAA443322, 1'b0, 0);
        run("lwl3", OPCODE_LWL, 32'h4003, 32'hAABBCCDD, 32'h44332211, 0, 1, 0, 4'b1111, 32'h0,
            32'h44332211, 1'b0, 0);
        run("sh", OPCODE_SH, 32'h5002, 32'h1234BEEF, 32'h0, 0, 1, 1, 4'b1100, 32'hBEEFBEEF,
            32'h0, 1'b0, 0);
        run("sw", OPCODE_SW, 32'h6000, 32'h01020304, 32'h0, 1, 1, 1, 4'b1111, 32'h01020304,
            32'h0, 1'b0, 1);
        run("lh", OPCODE_LH, 32'h7000, 32'h0, 32'h00008765, 0, 1, 0, 4'b0011, 32'h0,
            32'hFFFF8765, 1'b0, 0);
        run("lbu", OPCODE_LBU, 32'h7001, 32'h0, 32'h0000F100, 2, 1, 0, 4'b0010, 32'h0,
            32'h000000F1, 1'b0, 0);
        run("unsup", 6'h3F, 32'h7000, 32'h0, 32'h12345678, 0, 0, 0, 4'b0000, 32'h0,
            32'h0, 1'b0, 0);
`ifdef MISALIGN_TRAP_EN
        run("lw_mis", OPCODE_LW, 32'h3002, 32'h0, 32'hDEADBEEF, 0, 0, 0, 4'b0000, 32'h0,
            32'h0, 1'b1, 0);
        run("lh_mis", OPCODE_LH, 32'h3001, 32'h0, 32'hDEADBEEF, 0, 0, 0, 4'b0000, 32'h0,
            32'h0, 1'b1, 0);
`else
        run("lw_mis", OPCODE_LW, 32'h3002, 32'h0, 32'hDEADBEEF, 0, 1, 0, 4'b1111, 32'h0,
            32'hDEADBEEF, 1'b0, 0);
        run("lh_mis", OPCODE_LH, 32'h3001, 32'h0, 32'h0000FACE, 0, 1, 0, 4'b0011, 32'h0,
            32'hFFFFFACE, 1'b0, 0);
`endif

        // reset in the middle of a stalled read
        @(negedge clk);
        start = 1'b1; opcode = OPCODE_LW; eff_address = 32'h8000; mem_waitrequest = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst rd", {31'd0, mem_read}, 32'd1);
        chk("pre_rst busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst rd", {31'd0, mem_read}, 32'd0);
        chk("mid_rst busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; mem_waitrequest = 1'b0;
        run("post_rst", OPCODE_LW, 32'h9000, 32'h0, 32'hCAFEF00D, 1, 1, 0, 4'b1111, 32'h0,
            32'hCAFEF00D, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
